// File: rtl/fifo_ptr_ctrl.sv
// Pointer, flag and error controller for a synchronous FIFO built around a 2**ADDR_W entry RAM.
// Request acceptance is combinational; pointers, occupancy, flags and sticky errors are registered.
module fifo_ptr_ctrl #(
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              push,
   input  logic              pop,
   output logic              wr_en,
   output logic              rd_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W:0]   occupancy,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic              overflow,
   output logic              underflow,
   output logic [1:0]        state_o
);

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_PARTIAL = 2'd1,
      S_FULL    = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_M1 = (ADDR_W+1)'((1 << ADDR_W) - 1);
   localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_LVL   = (ADDR_W+1)'(AE_LEVEL);

   state_t            state_q;
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   occ_q, occ_d;
   logic              empty_q, full_q, ae_q, af_q, ovf_q, udf_q;

   // Acceptance uses the registered flags, so a full FIFO never takes a push even if a pop is
   // issued in the same cycle (and symmetrically for empty).
   assign wr_en = push & ~full_q;
   assign rd_en = pop & ~empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(wr_en);
      rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(rd_en);
      occ_d    = occ_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(rd_en);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q  <= S_EMPTY;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ae_q     <= 1'b1;
         af_q     <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         ae_q     <= (occ_d <= AE_LVL);
         af_q     <= (occ_d >= AF_LVL);
         ovf_q    <= ovf_q | (push & full_q);
         udf_q    <= udf_q | (pop & empty_q);
         case (state_q)
            S_EMPTY: begin
               if (wr_en) begin
                  state_q <= S_PARTIAL;
                  empty_q <= 1'b0;
               end
            end
            S_PARTIAL: begin
               if (wr_en && !rd_en && occ_q == DEPTH_M1) begin
                  state_q <= S_FULL;
                  full_q  <= 1'b1;
               end else if (rd_en && !wr_en && occ_q == ONE) begin
                  state_q <= S_EMPTY;
                  empty_q <= 1'b1;
               end
            end
            S_FULL: begin
               if (rd_en) begin
                  state_q <= S_PARTIAL;
                  full_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_EMPTY;
               empty_q <= 1'b1;
               full_q  <= 1'b0;
            end
         endcase
      end
   end

   assign wr_addr      = wr_ptr_q[ADDR_W-1:0];
   assign rd_addr      = rd_ptr_q[ADDR_W-1:0];
   assign occupancy    = occ_q;
   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_empty = ae_q;
   assign almost_full  = af_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Randomized and directed bench for fifo_ptr_ctrl; a count/pointer reference model feeds an
// expected queue that a separate monitor drains each committed cycle.
module tb_fifo_ptr_ctrl;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic       wr_en, rd_en;
   logic [3:0] wr_addr, rd_addr;
   logic [4:0] occupancy;
   logic       empty, full, almost_empty, almost_full, overflow, underflow;
   logic [1:0] state_o;

   fifo_ptr_ctrl #(.ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
      .clk(clk), .clr(clr), .push(push), .pop(pop),
      .wr_en(wr_en), .rd_en(rd_en), .wr_addr(wr_addr), .rd_addr(rd_addr),
      .occupancy(occupancy), .empty(empty), .full(full),
      .almost_empty(almost_empty), .almost_full(almost_full),
      .overflow(overflow), .underflow(underflow), .state_o(state_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Expected entry: [20:11] = {wr_en, rd_en, wr_addr, rd_addr} before the edge,
   //                 [10:0]  = {occupancy, empty, full, ae, af, overflow, underflow} after it.
   logic [20:0] exp_q[$];
   logic        act = 1'b0;

   // Reference model: plain entry count plus free-running pointers modulo 32.
   int m_cnt = 0, m_wr = 0, m_rd = 0;
   bit m_ovf = 0, m_udf = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [10:0] model_post();
      logic [4:0] occ;
      occ = 5'(m_cnt);
      return {occ, m_cnt == 0, m_cnt == 16, m_cnt <= 2, m_cnt >= 14, m_ovf, m_udf};
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_wr = 0; m_rd = 0; m_ovf = 0; m_udf = 0;
   endtask

   task automatic step(input bit p, input bit q);
      bit         acc_w, acc_r;
      logic [3:0] wa, ra;
      @(negedge clk);
      push = p;
      pop  = q;
      act  = 1'b1;
      acc_w = p && (m_cnt < 16);
      acc_r = q && (m_cnt > 0);
      wa = 4'(m_wr % 16);
      ra = 4'(m_rd % 16);
      if (p && m_cnt == 16) m_ovf = 1;
      if (q && m_cnt == 0) m_udf = 1;
      m_cnt = m_cnt + int'(acc_w) - int'(acc_r);
      m_wr  = (m_wr + int'(acc_w)) % 32;
      m_rd  = (m_rd + int'(acc_r)) % 32;
      exp_q.push_back({acc_w, acc_r, wa, ra, model_post()});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         push = 1'b0;
         pop  = 1'b0;
         act  = 1'b0;
      end
   endtask

   // Asserts clr between edges and checks that outputs clear before the next edge.
   task automatic mid_reset(input string tag);
      idle(1);
      @(posedge clk);
      #2 clr = 1'b1;
      #1;
      model_reset();
      check({tag, "_flags"}, {occupancy, empty, full, almost_empty, almost_full, overflow, underflow},
            {16'd0, model_post()});
      check({tag, "_addr"}, {wr_addr, rd_addr}, 8'h00);
      @(negedge clk);
      clr = 1'b0;
   endtask

   // Monitor: captures combinational outputs late in the low phase, flags just after the edge.
   initial begin
      logic        act_s;
      logic [9:0]  c_pre;
      logic [20:0] e;
      forever begin
         @(negedge clk);
         #3;
         act_s = act;
         c_pre = {wr_en, rd_en, wr_addr, rd_addr};
         @(posedge clk);
         #1;
         if (act_s) begin
            if (exp_q.size() == 0) begin
               check("queue_underrun", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("comb", {22'd0, c_pre}, {22'd0, e[20:11]});
               check("flags", {21'd0, occupancy, empty, full, almost_empty, almost_full, overflow, underflow},
                     {21'd0, e[10:0]});
            end
         end
         check("full_and_empty", {31'd0, full & empty}, 32'd0);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1: power-up reset
      #12;
      check("reset_flags", {occupancy, empty, full, almost_empty, almost_full, overflow, underflow},
            {16'd0, 11'b00000_1_0_1_0_0_0});
      check("reset_addr", {wr_addr, rd_addr}, 8'h00);
      @(negedge clk);
      clr = 1'b0;

      // 2: fill, then overflow push
      for (int i = 0; i < 16; i++) step(1, 0);
      step(1, 0);
      // 3: drain, then underflow pop
      for (int i = 0; i < 16; i++) step(0, 1);
      step(0, 1);

      // 4: simultaneous ops at 5, at empty, at full
      mid_reset("rst4");
      for (int i = 0; i < 5; i++) step(1, 0);
      for (int i = 0; i < 10; i++) step(1, 1);
      for (int i = 0; i < 5; i++) step(0, 1);
      step(1, 1);
      for (int i = 0; i < 15; i++) step(1, 0);
      step(1, 1);

      // 5: wrap-around with one-in-one-out
      mid_reset("rst5");
      for (int i = 0; i < 40; i++) begin
         step(1, 0);
         step(0, 1);
      end

      // 6: async reset at occupancy 9, then a push must land at address 0
      for (int i = 0; i < 9; i++) step(1, 0);
      mid_reset("rst6");
      step(1, 0);
      step(0, 1);

      // Random traffic: push-heavy, then pop-heavy, then balanced
      for (int i = 0; i < 150; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
      for (int i = 0; i < 150; i++) step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      mid_reset("rst7");
      for (int i = 0; i < 200; i++) step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);

      idle(4);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
